pointwise_mul_issue: RTL and testbench

POINTWISE_MUL_ISSUE -- requirements
Module: pointwise_mul_issue

---
 rtl/dilithium_pkg.sv | 17 +
 rtl/pointwise_mul_issue_coeff_mul.sv | 31 +++
 rtl/pointwise_mul_issue.sv | 132 +++++++++++++
 tb/tb_pointwise_mul_issue.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dilithium_pkg.sv
// Shared constants and FSM encoding for the Dilithium pointwise-multiply datapath.
package dilithium_pkg;

  localparam int unsigned Q          = 8380417;
  localparam int unsigned Q_WIDTH    = 23;
  localparam int unsigned DATA_WIDTH = 48;
  localparam int unsigned N_COEFF    = 256;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_MUL   = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_OUT   = 3'd4
  } state_t;

endpackage

// File: rtl/pointwise_mul_issue_coeff_mul.sv
// coeff_mul: Q_WIDTH x Q_WIDTH unsigned multiplier with a registered,
// zero-extended DATA_WIDTH result. The register only loads when en is high,
// so the product stays stable for the reducer until the next load.
module coeff_mul #(
  parameter int DATA_WIDTH = 48,
  parameter int Q_WIDTH    = 23
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [Q_WIDTH-1:0]    a,
  input  logic [Q_WIDTH-1:0]    b,
  output logic [DATA_WIDTH-1:0] prod
);

  localparam int PW = 2 * Q_WIDTH;

  logic [PW-1:0] full_p0;

  assign full_p0 = PW'(a) * PW'(b);

  // Product register: loads once per coefficient, held otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod <= '0;
    end else if (en) begin
      prod <= DATA_WIDTH'(full_p0);
    end
  end

endmodule

// File: rtl/pointwise_mul_issue.sv
// pointwise_mul_issue: accepts one coefficient pair, multiplies it, issues the
// product to an external reducer, waits for its result and streams it out.
// Optional feature: define OPERAND_CHECK_EN to add the operand_err output,
// which flags accepted operands that are not reduced modulo Q.
module pointwise_mul_issue #(
  parameter int DATA_WIDTH = dilithium_pkg::DATA_WIDTH,
  parameter int Q_WIDTH    = dilithium_pkg::Q_WIDTH,
  parameter int N_COEFF    = dilithium_pkg::N_COEFF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [Q_WIDTH-1:0]    a_in,
  input  logic [Q_WIDTH-1:0]    b_in,
  output logic                  red_start,
  output logic [DATA_WIDTH-1:0] red_data,
  input  logic                  red_done,
  input  logic [Q_WIDTH-1:0]    red_result,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [Q_WIDTH-1:0]    out_data,
  output logic                  out_last,
  output logic                  busy
`ifdef OPERAND_CHECK_EN
  ,
  output logic                  operand_err
`endif
);

  import dilithium_pkg::*;

  localparam int CNT_W = (N_COEFF > 1) ? $clog2(N_COEFF) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_COEFF - 1);

  state_t             state;
  logic [CNT_W-1:0]   coeff_cnt;
  logic [Q_WIDTH-1:0] a_p0;
  logic [Q_WIDTH-1:0] b_p0;
  logic               accept;
  logic               mul_en;

  assign accept = (state == S_IDLE) && in_valid;
  assign mul_en = (state == S_MUL);

  // Operand capture on acceptance; operands pass through unreduced
  always_ff @(posedge clk) begin
    if (accept) begin
      a_p0 <= a_in;
      b_p0 <= b_in;
    end
  end

  // Stage p0 -> p1: product registered in MUL, held through ISSUE and WAIT
  coeff_mul #(
    .DATA_WIDTH (DATA_WIDTH),
    .Q_WIDTH    (Q_WIDTH)
  ) u_coeff_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (mul_en),
    .a     (a_p0),
    .b     (b_p0),
    .prod  (red_data)
  );

  // Control FSM with registered handshake outputs and coefficient counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      coeff_cnt <= '0;
      in_ready  <= 1'b1;
      red_start <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            state    <= S_MUL;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        S_MUL: begin
          state     <= S_ISSUE;
          red_start <= 1'b1;
        end
        S_ISSUE: begin
          state     <= S_WAIT;
          red_start <= 1'b0;
        end
        S_WAIT: begin
          // red_done is only meaningful here; elsewhere it is ignored
          if (red_done) begin
            state     <= S_OUT;
            out_valid <= 1'b1;
            out_data  <= red_result;
            out_last  <= (coeff_cnt == LAST_IDX);
          end
        end
        S_OUT: begin
          if (out_ready) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            coeff_cnt <= (coeff_cnt == LAST_IDX) ? '0 : coeff_cnt + 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef OPERAND_CHECK_EN
  // One-cycle flag for an accepted operand that is not below Q
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      operand_err <= 1'b0;
    end else begin
      operand_err <= accept && ((a_in >= Q_WIDTH'(Q)) || (b_in >= Q_WIDTH'(Q)));
    end
  end
`endif

endmodule

// File: tb/tb_pointwise_mul_issue.sv
// Directed testbench for pointwise_mul_issue; the bench plays the reducer.
module tb_pointwise_mul_issue;

  localparam int DW = 48;
  localparam int QW = 23;
  localparam logic [QW-1:0] QV = 23'd8380417;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [QW-1:0] a_in;
  logic [QW-1:0] b_in;
  logic          red_start;
  logic [DW-1:0] red_data;
  logic          red_done;
  logic [QW-1:0] red_result;
  logic          out_valid;
  logic          out_ready;
  logic [QW-1:0] out_data;
  logic          out_last;
  logic          busy;
`ifdef OPERAND_CHECK_EN
  logic          operand_err;
  int            err_pulses = 0;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  pointwise_mul_issue dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a_in       (a_in),
    .b_in       (b_in),
    .red_start  (red_start),
    .red_data   (red_data),
    .red_done   (red_done),
    .red_result (red_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .busy       (busy)
`ifdef OPERAND_CHECK_EN
    ,
    .operand_err(operand_err)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

`ifdef OPERAND_CHECK_EN
  always @(negedge clk) if (operand_err === 1'b1) err_pulses <= err_pulses + 1;
`endif

  initial begin
    #1000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One full transaction; caller is positioned just after a falling edge.
  task automatic run_pair(input logic [QW-1:0] a, input logic [QW-1:0] b,
                          input logic [QW-1:0] res, input int lat, input int stall,
                          output logic [DW-1:0] rd, output int pulses,
                          output logic [QW-1:0] od, output logic ol,
                          output logic ov, output logic ov_after,
                          output logic held_bad, output int issue_cyc);
    bit found;
    logic [QW-1:0] od0;
    logic ol0;
    pulses = 0; held_bad = 1'b0; rd = '0; issue_cyc = 0; found = 0;
    in_valid = 1'b1; a_in = a; b_in = b;
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 8 && !found; k++) begin
      if (red_start === 1'b1) begin
        found = 1; pulses++; rd = red_data; issue_cyc = cyc;
      end else begin
        @(negedge clk);
      end
    end
    if (!found) begin
      checks++; errors++;
      $display("FAIL issue_timeout red_start=%0b required 1", red_start);
    end
    for (int j = 0; j < lat; j++) begin
      @(negedge clk);
      if (red_start === 1'b1) pulses++;
      if (red_data !== rd) held_bad = 1'b1;
    end
    red_done = 1'b1; red_result = res;
    @(negedge clk);
    red_done = 1'b0; red_result = '0;
    if (red_start === 1'b1) pulses++;
    ov = out_valid; od0 = out_data; ol0 = out_last;
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || out_data !== od0 || out_last !== ol0 || in_ready !== 1'b0)
        held_bad = 1'b1;
    end
    od = out_data; ol = out_last; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    ov_after = out_valid;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; a_in = '0; b_in = '0;
    red_done = 1'b0; red_result = '0; out_ready = 1'b0;
    #1;
    checks++; if (red_start !== 1'b0) begin errors++; $display("FAIL reset_red_start got %0b exp 0", red_start); end
    checks++; if (red_data !== '0) begin errors++; $display("FAIL reset_red_data got %0d exp 0", red_data); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b exp 0", out_valid); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data got %0d exp 0", out_data); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last got %0b exp 0", out_last); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", busy); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b exp 1", in_ready); end
  endtask

  task automatic test_small;
    logic [DW-1:0] rd; int p; logic [QW-1:0] od; logic ol, ov, ova, hb; int ic;
    run_pair(23'd2, 23'd3, 23'd6, 1, 0, rd, p, od, ol, ov, ova, hb, ic);
    checks++; if (rd !== 48'd6) begin errors++; $display("FAIL small_red_data got %0d exp 6", rd); end
    checks++; if (p !== 1) begin errors++; $display("FAIL small_start_pulses got %0d exp 1", p); end
    checks++; if (ov !== 1'b1) begin errors++; $display("FAIL small_out_valid got %0b exp 1", ov); end
    checks++; if (od !== 23'd6) begin errors++; $display("FAIL small_out_data got %0d exp 6", od); end
    checks++; if (ol !== 1'b0) begin errors++; $display("FAIL small_out_last got %0b exp 0", ol); end
    checks++; if (ova !== 1'b0) begin errors++; $display("FAIL small_out_valid_drop got %0b exp 0", ova); end
  endtask

  task automatic test_max;
    logic [DW-1:0] rd; int p; logic [QW-1:0] od; logic ol, ov, ova, hb; int ic;
    run_pair(23'd8380416, 23'd8380416, 23'd1, 2, 0, rd, p, od, ol, ov, ova, hb, ic);
    checks++; if (rd !== 48'd70231372333056) begin errors++; $display("FAIL max_red_data got %0d exp 70231372333056", rd); end
    checks++; if (p !== 1) begin errors++; $display("FAIL max_start_pulses got %0d exp 1", p); end
    checks++; if (od !== 23'd1) begin errors++; $display("FAIL max_out_data got %0d exp 1", od); end
  endtask

  task automatic test_stall;
    logic [DW-1:0] rd; int p; logic [QW-1:0] od; logic ol, ov, ova, hb; int ic;
    run_pair(23'd1000, 23'd3000, 23'd4242, 3, 5, rd, p, od, ol, ov, ova, hb, ic);
    checks++; if (hb !== 1'b0) begin errors++; $display("FAIL stall_hold got %0b exp 0", hb); end
    checks++; if (rd !== 48'd3000000) begin errors++; $display("FAIL stall_red_data got %0d exp 3000000", rd); end
    checks++; if (od !== 23'd4242) begin errors++; $display("FAIL stall_out_data got %0d exp 4242", od); end
    checks++; if (ova !== 1'b0) begin errors++; $display("FAIL stall_release got %0b exp 0", ova); end
  endtask

  task automatic test_back_to_back;
    logic [DW-1:0] rd; int p; logic [QW-1:0] od; logic ol, ov, ova, hb; int c1, c2;
    run_pair(23'd10, 23'd20, 23'd200, 1, 0, rd, p, od, ol, ov, ova, hb, c1);
    checks++; if (od !== 23'd200) begin errors++; $display("FAIL b2b_first_data got %0d exp 200", od); end
    run_pair(23'd7, 23'd9, 23'd63, 1, 0, rd, p, od, ol, ov, ova, hb, c2);
    checks++; if (rd !== 48'd63) begin errors++; $display("FAIL b2b_second_red_data got %0d exp 63", rd); end
    checks++; if (c2 - c1 !== 5) begin errors++; $display("FAIL b2b_issue_spacing got %0d exp 5", c2 - c1); end
  endtask

  task automatic test_reset_in_wait;
    bit found; bit seen;
    found = 0; seen = 0;
    in_valid = 1'b1; a_in = 23'd100; b_in = 23'd100;
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 8 && !found; k++) begin
      if (red_start === 1'b1) found = 1;
      else @(negedge clk);
    end
    checks++; if (!found) begin errors++; $display("FAIL rstwait_issue got 0 exp 1"); end
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstwait_busy_before got %0b exp 1", busy); end
    rst_n = 1'b0;
    #1;
    checks++; if (red_data !== '0) begin errors++; $display("FAIL rstwait_red_data got %0d exp 0", red_data); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL rstwait_out_data got %0d exp 0", out_data); end
    checks++; if ({red_start, out_valid, out_last, busy} !== 4'b0) begin
      errors++; $display("FAIL rstwait_ctrl got %b exp 0000", {red_start, out_valid, out_last, busy});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    red_done = 1'b1; red_result = 23'd77;
    @(negedge clk);
    red_done = 1'b0; red_result = '0;
    repeat (4) begin
      if (out_valid === 1'b1) seen = 1;
      @(negedge clk);
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rstwait_stray_done got %0b exp 0", seen); end
    checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL rstwait_idle got in_ready=%0b busy=%0b exp 1 0", in_ready, busy);
    end
  endtask

  task automatic test_wrap;
    logic [DW-1:0] rd; int p; logic [QW-1:0] od; logic ol, ov, ova, hb; int ic;
    logic exp_last; logic [QW-1:0] v;
    for (int i = 0; i < 257; i++) begin
      v = QW'(i + 1);
      run_pair(v, 23'd1, v, 1, 0, rd, p, od, ol, ov, ova, hb, ic);
      exp_last = (i == 255);
      checks++; if (ol !== exp_last) begin errors++; $display("FAIL wrap_last[%0d] got %0b exp %0b", i, ol, exp_last); end
      checks++; if (od !== v) begin errors++; $display("FAIL wrap_data[%0d] got %0d exp %0d", i, od, v); end
    end
  endtask

`ifdef OPERAND_CHECK_EN
  task automatic test_operand_err;
    logic [DW-1:0] rd; int p; logic [QW-1:0] od; logic ol, ov, ova, hb; int ic; int e0;
    e0 = err_pulses;
    run_pair(23'd2, 23'd3, 23'd6, 1, 0, rd, p, od, ol, ov, ova, hb, ic);
    checks++; if (err_pulses - e0 !== 0) begin errors++; $display("FAIL operr_clean got %0d exp 0", err_pulses - e0); end
    e0 = err_pulses;
    run_pair(QV, 23'd1, 23'd0, 1, 0, rd, p, od, ol, ov, ova, hb, ic);
    checks++; if (err_pulses - e0 !== 1) begin errors++; $display("FAIL operr_pulses got %0d exp 1", err_pulses - e0); end
    checks++; if (rd !== 48'd8380417) begin errors++; $display("FAIL operr_red_data got %0d exp 8380417", rd); end
    checks++; if (od !== 23'd0) begin errors++; $display("FAIL operr_out_data got %0d exp 0", od); end
  endtask
`endif

  initial begin
    test_reset();
    test_small();
    test_max();
    test_stall();
    test_back_to_back();
    test_reset_in_wait();
    test_wrap();
`ifdef OPERAND_CHECK_EN
    test_operand_err();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
